// File: rtl/nor_share_arb.sv
// nor_share_arb: one registered masked-NOR reduction unit shared by NREQ
// requesters through a round-robin arbiter and a single-entry output register
// with backpressure.
// Optional per-requester grant counters are enabled by defining
// NOR_SHARE_ARB_STATS_EN.

module nor_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 128,
    localparam int unsigned IDW  = $clog2(NREQ),
    localparam int unsigned CNTW = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*WIDTH-1:0] req_mask,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic                  res_nor,
    output logic [CNTW-1:0]       res_cnt
`ifdef NOR_SHARE_ARB_STATS_EN
    ,
    input  logic [IDW-1:0]        stat_sel,
    input  logic                  stat_clr,
    output logic [15:0]           stat_cnt
`endif
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    localparam logic [IDW:0] NreqW = (IDW + 1)'(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  res_id_q;
    logic            res_nor_q;
    logic [CNTW-1:0] res_cnt_q;

    logic            accept_ok;
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic            accept;
    logic [IDW:0]    scan;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] sel_mask;
    logic            nor_d;
    logic [CNTW-1:0] cnt_d;

    // Round-robin search from the pointer; the lowest offset with a valid wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (scan >= NreqW) begin
                scan = scan - NreqW;
            end
            if (req_valid[scan[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan[IDW-1:0];
            end
        end
    end

    // Output register has room when empty or draining this cycle.
    assign accept_ok = (state_q == StEmpty) || res_ready;
    assign accept    = accept_ok && grant_any;

    // One-hot grant, forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Only the granted requester's operand reaches the reduction.
    always_comb begin
        sel_data = req_data[grant_idx*WIDTH +: WIDTH];
        sel_mask = req_mask[grant_idx*WIDTH +: WIDTH];
        nor_d    = ~|(sel_data & sel_mask);
        cnt_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d = cnt_d + CNTW'(sel_mask[i]);
        end
    end

    // Next state for the output register and the round-robin pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = StFull;
            if ({1'b0, grant_idx} == NreqW - 1'b1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end else if (res_ready) begin
            state_d = StEmpty;
        end
    end

    // State, pointer and result payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            ptr_q     <= '0;
            res_id_q  <= '0;
            res_nor_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                res_id_q  <= grant_idx;
                res_nor_q <= nor_d;
                res_cnt_q <= cnt_d;
            end
        end
    end

    assign res_valid = (state_q == StFull);
    assign res_id    = res_id_q;
    assign res_nor   = res_nor_q;
    assign res_cnt   = res_cnt_q;

`ifdef NOR_SHARE_ARB_STATS_EN
    logic [15:0] stat_q [NREQ];

    // Saturating per-requester grant counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (accept && (stat_q[grant_idx] != 16'hFFFF)) begin
            stat_q[grant_idx] <= stat_q[grant_idx] + 16'd1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_nor_share_arb.sv
// Scoreboard bench for nor_share_arb: stimulus pushes hand-computed results,
// a monitor pops and compares on every result handshake.
// Stats checks are compiled in when NOR_SHARE_ARB_STATS_EN is defined.

module tb_nor_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 128;
    localparam int IDW   = 2;
    localparam int CNTW  = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*WIDTH-1:0] req_mask;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic                  res_nor;
    logic [CNTW-1:0]       res_cnt;
`ifdef NOR_SHARE_ARB_STATS_EN
    logic [IDW-1:0]        stat_sel;
    logic                  stat_clr;
    logic [15:0]           stat_cnt;
`endif

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic            nor_v;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [WIDTH-1:0] all_ones;
    logic [WIDTH-1:0] top_bit;
    logic             rr_nor [NREQ];
    logic [CNTW-1:0]  rr_cnt [NREQ];

    nor_share_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_nor   (res_nor),
        .res_cnt   (res_cnt)
`ifdef NOR_SHARE_ARB_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int id, input int nv, input int cnt);
        exp_t e;
        e.id    = IDW'(id);
        e.nor_v = nv[0];
        e.cnt   = CNTW'(cnt);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        req_data[i*WIDTH +: WIDTH] = d;
        req_mask[i*WIDTH +: WIDTH] = m;
    endtask

    // Check the grant mid-cycle, queue the expected result, advance one cycle.
    task automatic step(input string name, input logic [NREQ-1:0] exp_ready, input exp_t e);
        @(negedge clk);
        chk(name, 32'(req_ready), 32'(exp_ready));
        if (exp_ready != '0) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk(name, 32'(res_valid), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every result handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_id", 32'(res_id), 32'(mon_e.id));
                chk("res_nor", 32'(res_nor), 32'(mon_e.nor_v));
                chk("res_cnt", 32'(res_cnt), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        all_ones = '1;
        top_bit  = '0;
        top_bit[WIDTH-1] = 1'b1;
        rr_nor[0] = 1'b1; rr_cnt[0] = 8'd4;
        rr_nor[1] = 1'b0; rr_cnt[1] = 8'd8;
        rr_nor[2] = 1'b1; rr_cnt[2] = 8'd8;
        rr_nor[3] = 1'b0; rr_cnt[3] = 8'd16;

        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_mask  = '0;
        res_ready = 1'b1;
`ifdef NOR_SHARE_ARB_STATS_EN
        stat_sel  = '0;
        stat_clr  = 1'b0;
`endif

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_nor", 32'(res_nor), 32'd0);
        chk("rst_res_cnt", 32'(res_cnt), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        repeat (10) begin
            step("idle_ready", 4'b0000, mk(0, 0, 0));
            chk("idle_res_valid", 32'(res_valid), 32'd0);
        end

        // Single request, then same with zero data
        set_req(2, 128'h8, 128'hF);
        req_valid = 4'b0100;
        step("single_grant", 4'b0100, mk(2, 0, 4));
        chk("single_latency", 32'(res_valid), 32'd1);
        set_req(2, 128'h0, 128'hF);
        step("single_grant_zero", 4'b0100, mk(2, 1, 4));
        req_valid = '0;
        step("single_idle", 4'b0000, mk(0, 0, 0));

        // Round-robin from a fresh pointer
        pulse_reset("rr_reset_valid");
        set_req(0, 128'h0,    128'hF);
        set_req(1, 128'h1,    128'hFF);
        set_req(2, 128'h100,  128'hFF);
        set_req(3, 128'h8000, 128'hFFFF);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step("rr_grant", 4'(1 << (k % 4)),
                 mk(k % 4, int'(rr_nor[k % 4]), int'(rr_cnt[k % 4])));
        end
        req_valid = '0;
        step("rr_idle", 4'b0000, mk(0, 0, 0));

        // Backpressure: pointer is 2, requester 1 alone wins
        req_valid = 4'b0010;
        step("bp_accept", 4'b0010, mk(1, 0, 8));
        res_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (3) begin
            step("bp_ready", 4'b0000, mk(0, 0, 0));
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_id", 32'(res_id), 32'd1);
            chk("bp_nor", 32'(res_nor), 32'd0);
            chk("bp_cnt", 32'(res_cnt), 32'd8);
        end
        res_ready = 1'b1;
        step("bp_release", 4'b0100, mk(2, 1, 8));
        chk("bp_refill_valid", 32'(res_valid), 32'd1);
        chk("bp_refill_id", 32'(res_id), 32'd2);
        req_valid = '0;
        step("bp_idle", 4'b0000, mk(0, 0, 0));

        // Edge masks: pointer is 3
        set_req(0, all_ones, '0);
        req_valid = 4'b0001;
        step("mask_zero", 4'b0001, mk(0, 1, 0));
        set_req(3, top_bit, all_ones);
        req_valid = 4'b1000;
        step("mask_ones", 4'b1000, mk(3, 0, 128));
        req_valid = '0;
        step("mask_idle", 4'b0000, mk(0, 0, 0));

        // Reset mid-operation: pointer is 0
        set_req(1, 128'h0, 128'h3);
        req_valid = 4'b0010;
        repeat (5) step("mid_grant", 4'b0010, mk(1, 1, 2));
        req_valid = '0;
        res_ready = 1'b0;
        step("mid_hold", 4'b0000, mk(0, 0, 0));
        chk("mid_full", 32'(res_valid), 32'd1);
`ifdef NOR_SHARE_ARB_STATS_EN
        stat_sel = 2'd1;
        #1;
        chk("stat_five", 32'(stat_cnt), 32'd5);
`endif
        pulse_reset("mid_reset_valid");
        res_ready = 1'b1;
`ifdef NOR_SHARE_ARB_STATS_EN
        chk("stat_after_reset", 32'(stat_cnt), 32'd0);
`endif
        req_valid = 4'b1010;
        step("mid_after_reset", 4'b0010, mk(1, 1, 2));
`ifdef NOR_SHARE_ARB_STATS_EN
        chk("stat_one", 32'(stat_cnt), 32'd1);
        stat_clr  = 1'b1;
        req_valid = 4'b1000;
        step("stat_clr_grant", 4'b1000, mk(3, 0, 128));
        stat_clr  = 1'b0;
        chk("stat_clr_wins", 32'(stat_cnt), 32'd0);
        stat_sel = 2'd3;
        #1;
        chk("stat_clr_other", 32'(stat_cnt), 32'd0);
`endif
        req_valid = '0;
        step("final_idle", 4'b0000, mk(0, 0, 0));
        step("final_idle", 4'b0000, mk(0, 0, 0));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
